// File: rtl/glyph_pkg.sv
// Shared types, default geometry and address checking for the glyph bitmap store.
package glyph_pkg;

  typedef enum logic {StIdle, StClear} clear_state_e;

  localparam int unsigned DefGlyphW    = 4;
  localparam int unsigned DefGlyphH    = 5;
  localparam int unsigned DefNumGlyphs = 16;

  localparam logic [DefGlyphW*DefGlyphH-1:0] DefResetPattern = 20'hA5AA5;

  function automatic logic in_range(input int unsigned glyph, input int unsigned x,
                                    input int unsigned y, input int unsigned num_glyphs,
                                    input int unsigned glyph_w, input int unsigned glyph_h);
    return (glyph < num_glyphs) && (x < glyph_w) && (y < glyph_h);
  endfunction

endpackage

// File: rtl/glyph_clear_fsm.sv
// Background clear engine: walks every glyph row once, one row per cycle, then pulses done.
module glyph_clear_fsm
  import glyph_pkg::*;
#(
  parameter int unsigned NUM_GLYPHS = DefNumGlyphs,
  parameter int unsigned GLYPH_H    = DefGlyphH,
  localparam int unsigned GW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  localparam int unsigned YW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          clear_start,
  output logic          busy,
  output logic          done,
  output logic          clr_we,
  output logic [GW-1:0] clr_glyph,
  output logic [YW-1:0] clr_y
);

  clear_state_e  state_q, state_d;
  logic [GW-1:0] glyph_q, glyph_d;
  logic [YW-1:0] y_q, y_d;
  logic          done_q, done_d;
  logic          last_row;

  assign last_row = (glyph_q == GW'(NUM_GLYPHS - 1)) && (y_q == YW'(GLYPH_H - 1));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      glyph_q <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      glyph_q <= glyph_d;
      y_q     <= y_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    glyph_d = glyph_q;
    y_d     = y_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (clear_start) begin
          state_d = StClear;
          glyph_d = '0;
          y_d     = '0;
        end
      end
      StClear: begin
        if (last_row) begin
          state_d = StIdle;
          glyph_d = '0;
          y_d     = '0;
          done_d  = 1'b1;
        end else if (y_q == YW'(GLYPH_H - 1)) begin
          y_d     = '0;
          glyph_d = glyph_q + GW'(1);
        end else begin
          y_d = y_q + YW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy      = (state_q == StClear);
    clr_we    = (state_q == StClear);
    clr_glyph = glyph_q;
    clr_y     = y_q;
    done      = done_q;
  end

endmodule

// File: rtl/glyph_memory.sv
// Multi-glyph 1-bit bitmap store with a pixel write port and registered pixel read port.
// Optional background clear engine is built when GLYPH_MEMORY_CLEAR_EN is defined.
module glyph_memory
  import glyph_pkg::*;
#(
  parameter int unsigned GLYPH_W    = DefGlyphW,
  parameter int unsigned GLYPH_H    = DefGlyphH,
  parameter int unsigned NUM_GLYPHS = DefNumGlyphs,
  parameter logic [GLYPH_W*GLYPH_H-1:0] RESET_PATTERN = DefResetPattern,
  localparam int unsigned GW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1,
  localparam int unsigned XW = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1,
  localparam int unsigned YW = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [GW-1:0] wr_glyph,
  input  logic [XW-1:0] wr_x,
  input  logic [YW-1:0] wr_y,
  input  logic          wr_data,
  input  logic          rd_en,
  input  logic [GW-1:0] rd_glyph,
  input  logic [XW-1:0] rd_x,
  input  logic [YW-1:0] rd_y,
  output logic          rd_data,
  output logic          rd_valid,
  input  logic          clear_start,
  output logic          busy,
  output logic          done
);

  logic [GLYPH_W-1:0] mem_q [NUM_GLYPHS][GLYPH_H];

  logic          clr_we;
  logic [GW-1:0] clr_glyph;
  logic [YW-1:0] clr_y;
  logic          wr_ok, rd_ok, rd_bit;
  logic          rd_data_q, rd_valid_q;

`ifdef GLYPH_MEMORY_CLEAR_EN
  glyph_clear_fsm #(
    .NUM_GLYPHS(NUM_GLYPHS),
    .GLYPH_H   (GLYPH_H)
  ) u_clear_fsm (
    .clock      (clock),
    .rst_n      (rst_n),
    .clear_start(clear_start),
    .busy       (busy),
    .done       (done),
    .clr_we     (clr_we),
    .clr_glyph  (clr_glyph),
    .clr_y      (clr_y)
  );
`else
  logic unused_clear_start;
  assign unused_clear_start = clear_start;
  assign busy      = 1'b0;
  assign done      = 1'b0;
  assign clr_we    = 1'b0;
  assign clr_glyph = '0;
  assign clr_y     = '0;
`endif

  assign wr_ok = wr_en && !busy &&
                 in_range(32'(wr_glyph), 32'(wr_x), 32'(wr_y), NUM_GLYPHS, GLYPH_W, GLYPH_H);
  assign rd_ok = in_range(32'(rd_glyph), 32'(rd_x), 32'(rd_y), NUM_GLYPHS, GLYPH_W, GLYPH_H);

  always_comb begin
    rd_bit = 1'b0;
    if (rd_ok) rd_bit = mem_q[rd_glyph][rd_y][rd_x];
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned g = 0; g < NUM_GLYPHS; g++) begin
        for (int unsigned y = 0; y < GLYPH_H; y++) begin
          mem_q[g][y] <= RESET_PATTERN[y*GLYPH_W +: GLYPH_W];
        end
      end
    end else begin
      // Clear rows and host writes never coincide: host writes are blocked while busy.
      if (clr_we) mem_q[clr_glyph][clr_y] <= RESET_PATTERN[32'(clr_y)*GLYPH_W +: GLYPH_W];
      if (wr_ok) mem_q[wr_glyph][wr_y][wr_x] <= wr_data;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_bit;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_glyph_memory.sv
// Self-checking bench for glyph_memory: vector table, scoreboard-checked reads, clear/reset sequences.
module tb_glyph_memory;

  logic       clock = 1'b0;
  logic       rst_n;
  logic       wr_en, wr_data, rd_en, clear_start;
  logic [3:0] wr_glyph, rd_glyph;
  logic [1:0] wr_x, rd_x;
  logic [2:0] wr_y, rd_y;
  logic       rd_data, rd_valid, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {bit val; int due;} sb_t;
  sb_t sb[$];

  typedef struct {
    bit we; int wg; int wx; int wy; bit wd;
    bit re; int rg; int rx; int ry; bit ev;
  } vec_t;
  vec_t vecs[13];

  bit [19:0] pat = 20'hA5AA5;

  glyph_memory dut (
    .clock      (clock),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_glyph   (wr_glyph),
    .wr_x       (wr_x),
    .wr_y       (wr_y),
    .wr_data    (wr_data),
    .rd_en      (rd_en),
    .rd_glyph   (rd_glyph),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .clear_start(clear_start),
    .busy       (busy),
    .done       (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc = cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Read scoreboard: every expected read result must appear exactly one cycle after rd_en.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL rd_valid_missing: got no valid expected one at cycle %0d", sb[0].due);
      void'(sb.pop_front());
    end
    if (rst_n && rd_valid) begin
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL rd_valid_spurious: got valid=1 expected 0 at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        if (e.due != cyc || rd_data !== e.val) begin
          errors++;
          $display("FAIL rd_data: got %0b at cycle %0d expected %0b at cycle %0d",
                   rd_data, cyc, e.val, e.due);
        end
      end
    end
  end

  task automatic step(input bit we, input int wg, input int wx, input int wy, input bit wd,
                      input bit re, input int rg, input int rx, input int ry, input bit ev,
                      input bit cs);
    wr_en = we; wr_glyph = 4'(wg); wr_x = 2'(wx); wr_y = 3'(wy); wr_data = wd;
    rd_en = re; rd_glyph = 4'(rg); rd_x = 2'(rx); rd_y = 3'(ry);
    clear_start = cs;
    if (re) sb.push_back('{ev, cyc + 1});
    @(posedge clock);
    #1;
    wr_en = 1'b0; rd_en = 1'b0; clear_start = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic readback_all();
    for (int g = 0; g < 16; g++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 4; x++)
          step(0, 0, 0, 0, 0, 1, g, x, y, pat[y*4+x], 0);
    idle(2);
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    #1;
    check("async_reset_busy", int'(busy), 0);
    check("async_reset_done", int'(done), 0);
    check("async_reset_valid", int'(rd_valid), 0);
    @(posedge clock);
    @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bcnt, dcnt, order_bad;
    bit prev;
    wr_en = 0; wr_glyph = 0; wr_x = 0; wr_y = 0; wr_data = 0;
    rd_en = 0; rd_glyph = 0; rd_x = 0; rd_y = 0; clear_start = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check("reset_rd_data", int'(rd_data), 0);
    check("reset_rd_valid", int'(rd_valid), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    @(posedge clock);
    @(posedge clock);
    #1 rst_n = 1'b1;
    idle(1);

    //         we wg wx wy wd  re rg rx ry ev
    vecs[0]  = '{0, 0, 0, 0, 0, 1, 3, 0, 0, 1};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 3, 1, 0, 0};
    vecs[2]  = '{1, 7, 2, 4, 1, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 7, 2, 4, 1};
    vecs[4]  = '{0, 0, 0, 0, 0, 1, 6, 2, 4, 0};
    vecs[5]  = '{1, 0, 1, 5, 1, 1, 0, 0, 7, 0};
    vecs[6]  = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 0};
    vecs[7]  = '{1, 2, 0, 1, 1, 1, 2, 0, 1, 0};
    vecs[8]  = '{0, 0, 0, 0, 0, 1, 2, 0, 1, 1};
    vecs[9]  = '{0, 0, 0, 0, 0, 1, 15, 3, 4, 1};
    vecs[10] = '{0, 0, 0, 0, 0, 1, 5, 3, 3, 0};
    vecs[11] = '{1, 9, 3, 3, 1, 0, 0, 0, 0, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 9, 3, 3, 1};
    foreach (vecs[i])
      step(vecs[i].we, vecs[i].wg, vecs[i].wx, vecs[i].wy, vecs[i].wd,
           vecs[i].re, vecs[i].rg, vecs[i].rx, vecs[i].ry, vecs[i].ev, 0);

    // With rd_en low, rd_valid drops and rd_data keeps the last value (1).
    idle(1);
    @(negedge clock);
    check("hold_rd_valid", int'(rd_valid), 0);
    check("hold_rd_data", int'(rd_data), 1);
    @(posedge clock);
    #1;

`ifdef GLYPH_MEMORY_CLEAR_EN
    step(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 15, 1, 0, 1, 0, 0, 0, 0, 0, 0);
    step(1, 15, 2, 0, 0, 0, 0, 0, 0, 0, 1);
    bcnt = 0; dcnt = 0; order_bad = 0; prev = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (busy || !prev) order_bad++;
      end
      prev = busy;
      wr_en = (i == 40); wr_glyph = 0; wr_x = 0; wr_y = 0; wr_data = 0;
      clear_start = (i == 20);
      rd_en = (i == 2); rd_glyph = 15; rd_x = 0; rd_y = 0;
      if (i == 2) sb.push_back('{1'b0, cyc + 1});
    end
    wr_en = 0; rd_en = 0; clear_start = 0;
    check("clear_busy_cycles", bcnt, 80);
    check("clear_done_pulses", dcnt, 1);
    check("clear_done_after_busy", order_bad, 0);
    @(posedge clock);
    #1;
    readback_all();

    step(1, 15, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 8, 3, 2, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    repeat (30) @(posedge clock);
    check("busy_before_reset", int'(busy), 1);
    pulse_reset();
    dcnt = 0; bcnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    check("no_done_after_reset", dcnt, 0);
    check("no_busy_after_reset", bcnt, 0);
    @(posedge clock);
    #1;
    readback_all();
`else
    step(1, 4, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    bcnt = 0;
    repeat (100) begin
      @(negedge clock);
      if (busy || done) bcnt++;
    end
    check("noclear_busy_done", bcnt, 0);
    @(posedge clock);
    #1;
    step(0, 0, 0, 0, 0, 1, 4, 0, 1, 1, 0);
    idle(2);
    @(posedge clock);
    pulse_reset();
    idle(1);
    readback_all();
`endif

    idle(3);
    check("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
